baccarat_dealer: RTL and testbench
==================================

Name: baccarat_dealer

Overview:
- Sequences one baccarat round by loading dealt card codes into the player and dealer hand registers.
- It is the producer side of the scoring path. Its registered card outputs feed two scorehand instances.
- The resulting 4-bit scores (0-9) return as inputs and drive the third-card decisions and the win lights.
- Card codes: 1=A, 2-9 face value, 10-13 = 10/J/Q/K (value 0); code 0 = empty slot.

Parameters:
NATURAL_MIN, 8, a two-card score at or above this value is a natural and ends the deal.
PLAYER_DRAW_MAX, 5, player draws a third card when pscore is at or below this value.

Ports:
slow_clock  input  1  clock
resetb  input  1  asynchronous active-low reset
advance  input  1  one-cycle step request (already synchronised and edge-detected upstream)
new_card  input  4  card code offered by the card source; valid codes 1-13
pscore  input  4  player score from external scorehand on pcard1..3
dscore  input  4  dealer score from external scorehand on dcard1..3
pcard1, pcard2, pcard3  output  4 each  player hand registers
dcard1, dcard2, dcard3  output  4 each  dealer hand registers
player_win  output  1  player win light
dealer_win  output  1  dealer win light
done  output  1  round complete

Behaviour:
- Reset (resetb=0, asynchronous): all six card registers = 0, player_win = dealer_win = done = 0, state = P1.
- Deal states P1, D1, P2, D2, P3, D3:
  - Wait for advance=1 with new_card in 1..13.
  - On that edge, load new_card into the matching register and leave the state.
  - advance with new_card in {0,14,15} is ignored: no load, no state change.
- Held advance: every cycle with advance=1 in a deal state is a separate step.
- Transition order: P1->D1->P2->D2->EVAL1.
- EVAL1 (1 cycle, advance ignored): pscore/dscore are valid here because the cards are registered and scoring is combinational.
  - If pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> SCORE.
  - Else if pscore<=PLAYER_DRAW_MAX -> P3.
  - Else -> EVALD.
- EVALD (1 cycle, player stood): dscore<=5 -> D3, else SCORE.
- P3 -> EVAL2 after the load.
- EVAL2 (1 cycle, player drew): v = value of pcard3 (codes 10-13 give 0). Dealer draws (-> D3) when:
  - dscore 0-2: always.
  - dscore 3: v!=8.
  - dscore 4: v in 2..7.
  - dscore 5: v in 4..7.
  - dscore 6: v in 6..7.
  - dscore 7: never.
  - Otherwise -> SCORE.
- D3 -> SCORE after the load.
- SCORE (1 cycle): on exit, set the lights and done=1, then go to DONE.
  - pscore>dscore: player_win=1.
  - dscore>pscore: dealer_win=1.
  - Equal scores: both lights = 1.
- DONE:
  - Outputs hold.
  - advance (any new_card value) clears all cards, lights and done in the same edge, and returns to P1 without consuming a card.
- Outputs are registered; no combinational path from inputs to outputs.
- Latency, last card load to done=1:
  - 2 cycles when the path goes through EVAL1 -> SCORE.
  - 3 cycles from pcard3 load through EVAL2 -> SCORE.
  - 2 cycles from dcard3 load.
- Unused third-card registers remain 0.
- Reset asserted mid-round clears everything immediately; the round restarts at P1 after release.

Test Plan:
- Reset then release, no advance -> all cards 0, lights 0, done 0 after 20 cycles. Advance with new_card=0 in P1 -> pcard1 stays 0, state unchanged. Then new_card=4 -> pcard1=4.
- Natural: deal P1=4, D1=2, P2=5, D2=3 (pscore 9, dscore 5) -> pcard3=dcard3=0, player_win=1, dealer_win=0, done=1 two cycles after the D2 load.
- Player draws, dealer 3 stands on an 8: deal 1,1,2,2, then P3=8 -> pscore 1, dscore 3, dcard3=0, dealer_win=1, player_win=0.
- Player stands on 6, dealer 5 draws: deal 3,2,3,3, then D3=10 -> pcard3=0, dcard3=10, pscore 6, dscore 5, player_win=1.
- Tie: deal 10,13,7,7 (both 7, both stand) -> player_win=dealer_win=1, done=1. Advance in DONE -> all cards 0, lights 0, state P1.
- Reset mid-round: assert resetb=0 after the D1 load, between clock edges -> cards clear without waiting for an edge. Full round after release behaves per the natural scenario.

Source files
------------

// File: rtl/baccarat_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : baccarat_dealer
//  Description : Sequences one baccarat round. Loads dealt card codes into the
//                player/dealer hand registers. Applies the natural, player
//                third-card and dealer tableau rules using externally computed
//                hand scores, then lights the winner.
//  Revision    : 1.0  initial release
// ============================================================================
module baccarat_dealer #(
    parameter int NATURAL_MIN     = 8,
    parameter int PLAYER_DRAW_MAX = 5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       advance,
    input  logic [3:0] new_card,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    localparam logic [3:0] c_NATURAL_MIN     = 4'(NATURAL_MIN);
    localparam logic [3:0] c_PLAYER_DRAW_MAX = 4'(PLAYER_DRAW_MAX);

    typedef enum logic [3:0] {
        S_P1    = 4'd0,
        S_D1    = 4'd1,
        S_P2    = 4'd2,
        S_D2    = 4'd3,
        S_EVAL1 = 4'd4,
        S_EVALD = 4'd5,
        S_P3    = 4'd6,
        S_EVAL2 = 4'd7,
        S_D3    = 4'd8,
        S_SCORE = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pcard1_q, pcard1_d, pcard2_q, pcard2_d, pcard3_q, pcard3_d;
    logic [3:0] dcard1_q, dcard1_d, dcard2_q, dcard2_d, dcard3_q, dcard3_d;
    logic       player_win_q, player_win_d;
    logic       dealer_win_q, dealer_win_d;
    logic       done_q, done_d;

    logic       w_card_ok;
    logic [3:0] w_pcard3_val;
    logic       w_dealer_draw;

    // Baccarat value of a card code: A..9 count face value, tens and faces count 0.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        return (code <= 4'd9) ? code : 4'd0;
    endfunction

    // A deal step needs a real card on the source; empty/illegal codes are ignored.
    assign w_card_ok    = advance && (new_card >= 4'd1) && (new_card <= 4'd13);
    assign w_pcard3_val = card_value(pcard3_q);

    // Dealer tableau after the player drew, keyed on the dealer's two-card score.
    always_comb begin
        w_dealer_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: w_dealer_draw = 1'b1;
            4'd3:    w_dealer_draw = (w_pcard3_val != 4'd8);
            4'd4:    w_dealer_draw = (w_pcard3_val >= 4'd2) && (w_pcard3_val <= 4'd7);
            4'd5:    w_dealer_draw = (w_pcard3_val >= 4'd4) && (w_pcard3_val <= 4'd7);
            4'd6:    w_dealer_draw = (w_pcard3_val >= 4'd6) && (w_pcard3_val <= 4'd7);
            default: w_dealer_draw = 1'b0;
        endcase
    end

    // Next-state and next-output logic for the round sequencer.
    always_comb begin
        state_d      = state_q;
        pcard1_d     = pcard1_q;
        pcard2_d     = pcard2_q;
        pcard3_d     = pcard3_q;
        dcard1_d     = dcard1_q;
        dcard2_d     = dcard2_q;
        dcard3_d     = dcard3_q;
        player_win_d = player_win_q;
        dealer_win_d = dealer_win_q;
        done_d       = done_q;

        case (state_q)
            S_P1: if (w_card_ok) begin pcard1_d = new_card; state_d = S_D1; end
            S_D1: if (w_card_ok) begin dcard1_d = new_card; state_d = S_P2; end
            S_P2: if (w_card_ok) begin pcard2_d = new_card; state_d = S_D2; end
            S_D2: if (w_card_ok) begin dcard2_d = new_card; state_d = S_EVAL1; end
            S_P3: if (w_card_ok) begin pcard3_d = new_card; state_d = S_EVAL2; end
            S_D3: if (w_card_ok) begin dcard3_d = new_card; state_d = S_SCORE; end
            // Scores are combinational on registered cards, so they are valid here.
            S_EVAL1: begin
                if ((pscore >= c_NATURAL_MIN) || (dscore >= c_NATURAL_MIN))
                    state_d = S_SCORE;
                else if (pscore <= c_PLAYER_DRAW_MAX)
                    state_d = S_P3;
                else
                    state_d = S_EVALD;
            end
            // Player stood: dealer follows the same draw-on-5-or-less rule.
            S_EVALD: state_d = (dscore <= 4'd5) ? S_D3 : S_SCORE;
            S_EVAL2: state_d = w_dealer_draw ? S_D3 : S_SCORE;
            // A tie lights both lamps.
            S_SCORE: begin
                player_win_d = (pscore >= dscore);
                dealer_win_d = (dscore >= pscore);
                done_d       = 1'b1;
                state_d      = S_DONE;
            end
            // Any advance starts a fresh round without consuming a card.
            S_DONE: begin
                if (advance) begin
                    pcard1_d     = 4'd0;
                    pcard2_d     = 4'd0;
                    pcard3_d     = 4'd0;
                    dcard1_d     = 4'd0;
                    dcard2_d     = 4'd0;
                    dcard3_d     = 4'd0;
                    player_win_d = 1'b0;
                    dealer_win_d = 1'b0;
                    done_d       = 1'b0;
                    state_d      = S_P1;
                end
            end
            default: state_d = S_P1;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= S_P1;
            pcard1_q     <= 4'd0;
            pcard2_q     <= 4'd0;
            pcard3_q     <= 4'd0;
            dcard1_q     <= 4'd0;
            dcard2_q     <= 4'd0;
            dcard3_q     <= 4'd0;
            player_win_q <= 1'b0;
            dealer_win_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcard1_q     <= pcard1_d;
            pcard2_q     <= pcard2_d;
            pcard3_q     <= pcard3_d;
            dcard1_q     <= dcard1_d;
            dcard2_q     <= dcard2_d;
            dcard3_q     <= dcard3_d;
            player_win_q <= player_win_d;
            dealer_win_q <= dealer_win_d;
            done_q       <= done_d;
        end
    end

    assign pcard1     = pcard1_q;
    assign pcard2     = pcard2_q;
    assign pcard3     = pcard3_q;
    assign dcard1     = dcard1_q;
    assign dcard2     = dcard2_q;
    assign dcard3     = dcard3_q;
    assign player_win = player_win_q;
    assign dealer_win = dealer_win_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_dealer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baccarat_dealer
//  Description : Self-checking bench for baccarat_dealer. Provides the two
//                external scorehands and predicts each round from the dealt
//                card stream using the game rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_baccarat_dealer;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       advance    = 1'b0;
    logic [3:0] new_card   = 4'd0;
    logic [3:0] pscore, dscore;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic       player_win, dealer_win, done;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] deck [6];

    baccarat_dealer #(.NATURAL_MIN(8), .PLAYER_DRAW_MAX(5)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .advance    (advance),
        .new_card   (new_card),
        .pscore     (pscore),
        .dscore     (dscore),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .player_win (player_win),
        .dealer_win (dealer_win),
        .done       (done)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic int cv(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
    endfunction

    // External scorehands: hand total modulo 10.
    assign pscore = 4'((cv(pcard1) + cv(pcard2) + cv(pcard3)) % 10);
    assign dscore = 4'((cv(dcard1) + cv(dcard2) + cv(dcard3)) % 10);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic tick(input logic adv, input logic [3:0] card);
        advance  = adv;
        new_card = card;
        @(posedge slow_clock);
        #1;
        advance  = 1'b0;
        new_card = 4'd0;
    endtask

    function automatic logic [3:0] junk_card();
        int j;
        j = $urandom_range(0, 2);
        return (j == 0) ? 4'd0 : 4'(13 + j);
    endfunction

    // Deal the round held in deck[], predict it from the rules, and check it.
    task automatic play_round(input bit check_lat);
        int ps, ds, pv, n, lat, idle;
        bit pdraw, ddraw;
        logic [3:0] e_p3, e_d3;

        ps = (cv(deck[0]) + cv(deck[2])) % 10;
        ds = (cv(deck[1]) + cv(deck[3])) % 10;
        pdraw = 1'b0;
        ddraw = 1'b0;
        if (ps < 8 && ds < 8) begin
            if (ps <= 5) begin
                pdraw = 1'b1;
                pv = cv(deck[4]);
                case (ds)
                    0, 1, 2: ddraw = 1'b1;
                    3:       ddraw = (pv != 8);
                    4:       ddraw = (pv >= 2 && pv <= 7);
                    5:       ddraw = (pv >= 4 && pv <= 7);
                    6:       ddraw = (pv >= 6 && pv <= 7);
                    default: ddraw = 1'b0;
                endcase
            end else begin
                ddraw = (ds <= 5);
            end
        end
        n    = 4 + int'(pdraw) + int'(ddraw);
        e_p3 = pdraw ? deck[4] : 4'd0;
        e_d3 = ddraw ? deck[pdraw ? 5 : 4] : 4'd0;
        ps   = (cv(deck[0]) + cv(deck[2]) + cv(e_p3)) % 10;
        ds   = (cv(deck[1]) + cv(deck[3]) + cv(e_d3)) % 10;

        for (int k = 0; k < n; k++) begin
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) begin
                if ($urandom_range(0, 1) == 1) tick(1'b1, junk_card());
                else                           tick(1'b0, 4'($urandom_range(0, 15)));
            end
            tick(1'b1, deck[k]);
            // Valid cards offered during evaluation cycles must not be taken.
            if (k == 3 && n > 4) begin
                tick(1'b1, 4'($urandom_range(1, 13)));
                tick(1'b0, 4'd0);
            end
            if (k == 4 && pdraw && ddraw) tick(1'b1, 4'($urandom_range(1, 13)));
        end

        lat = 0;
        while (!done && lat < 10) begin
            tick(1'b0, 4'd0);
            lat++;
        end
        chk("done", 32'(done), 32'd1);
        if (check_lat) chk("latency", 32'(lat), 32'd2);
        chk("pcard1", 32'(pcard1), 32'(deck[0]));
        chk("dcard1", 32'(dcard1), 32'(deck[1]));
        chk("pcard2", 32'(pcard2), 32'(deck[2]));
        chk("dcard2", 32'(dcard2), 32'(deck[3]));
        chk("pcard3", 32'(pcard3), 32'(e_p3));
        chk("dcard3", 32'(dcard3), 32'(e_d3));
        chk("player_win", 32'(player_win), 32'(ps >= ds));
        chk("dealer_win", 32'(dealer_win), 32'(ds >= ps));

        tick(1'b0, 4'($urandom_range(0, 15)));
        chk("done_hold", 32'(done), 32'd1);

        tick(1'b1, 4'($urandom_range(0, 15)));
        chk("clear_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 32'd0);
        chk("clear_flags", 32'({player_win, dealer_win, done}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge slow_clock);
        #1 resetb = 1'b1;

        // Idle after reset.
        repeat (20) tick(1'b0, 4'd0);
        chk("rst_cards", 32'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}), 32'd0);
        chk("rst_flags", 32'({player_win, dealer_win, done}), 32'd0);
        tick(1'b1, 4'd0);
        chk("empty_card_ignored", 32'(pcard1), 32'd0);

        // Natural: player 9 vs dealer 5.
        deck = '{4'd4, 4'd2, 4'd5, 4'd3, 4'd0, 4'd0};
        play_round(1'b1);
        // Player draws an 8, dealer on 3 stands.
        deck = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd8, 4'd0};
        play_round(1'b0);
        // Player stands on 6, dealer on 5 draws a ten.
        deck = '{4'd3, 4'd2, 4'd3, 4'd3, 4'd10, 4'd0};
        play_round(1'b0);
        // Tie on 7.
        deck = '{4'd10, 4'd13, 4'd7, 4'd7, 4'd0, 4'd0};
        play_round(1'b0);

        // Reset between edges clears immediately.
        tick(1'b1, 4'd4);
        tick(1'b1, 4'd2);
        chk("pre_reset_dcard1", 32'(dcard1), 32'd2);
        #2 resetb = 1'b0;
        #1;
        chk("async_reset_cards", 32'({pcard1, dcard1}), 32'd0);
        @(posedge slow_clock);
        #1 resetb = 1'b1;
        deck = '{4'd4, 4'd2, 4'd5, 4'd3, 4'd0, 4'd0};
        play_round(1'b1);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 6; i++) deck[i] = 4'($urandom_range(1, 13));
            play_round(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
